se_lookup_arbiter: RTL and testbench
====================================

# se_lookup_arbiter

Shares the single MAC search engine (source-learn / destination-lookup port: se_mac, se_hash, se_source, se_req, se_ack, se_nak, se_result) between N ingress frame processors. Each requester holds its request for a whole lookup session, usually a source-learn followed by a destination lookup. The arbiter grants one requester per session in round-robin order, forwards that requester's lookup fields to the engine, and routes responses back to it only. It sits between the per-port frame processors and the search engine in the switch core.

## Interface
- N, 4: number of requesters (2..8).
- TIMEOUT, 255: engine response watchdog limit in cycles; only used with SE_ARB_TIMEOUT_EN.
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- req  in  N  per-requester se_req level.
- req_mac  in  48*N  per-requester se_mac; requester i occupies bits [48i+47:48i].
- req_hash  in  10*N  per-requester se_hash.
- req_source  in  N  per-requester se_source.
- req_ack  out  N  routed se_ack.
- req_nak  out  N  routed se_nak.
- req_result  out  16  se_result broadcast; valid only with the requester's ack.
- se_req / se_mac / se_hash / se_source  out  1/48/10/1  to the search engine.
- se_ack / se_nak  in  1  engine response strobes.
- se_result  in  16  engine result.
- grant  out  N  one-hot granted requester; all zeros when idle.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- The state machine has three states: IDLE, BUSY and FLUSH.
- IDLE:
  - If any req bit is high, select the first set bit strictly after last_grant, searching circularly.
  - Load grant (registered, one-hot) and go to BUSY.
  - last_grant resets to N-1, so requester 0 has priority first after reset.
- BUSY:
  - se_req, se_mac, se_hash and se_source are combinational muxes of the granted requester's inputs.
  - Field changes the requester makes on its ack cycle pass straight through.
  - se_ack and se_nak go to req_ack[g] and req_nak[g] only; every other req_ack and req_nak bit is 0.
  - If se_ack and se_nak arrive in the same cycle, both are forwarded unchanged.
- Session end:
  - When req[g] is low in BUSY, set last_grant to g, clear grant and go to IDLE.
  - Because of this, se_req is low for at least one cycle between sessions.
- Ignored responses: se_ack or se_nak while grant is zero is discarded and no requester sees it.
- When grant is zero, se_req, se_mac, se_hash and se_source are all 0.
- Unchanged: the arbiter never alters lookup fields and never reorders requests within a session.

## Timing
- Reset values: grant=0, se_req=0, se_mac=0, se_hash=0, se_source=0, req_ack=0, req_nak=0, err_timeout=0, state=IDLE, last_grant=N-1, watchdog=0.
- Grant latency: a req rising at cycle t, with the arbiter in IDLE, gives grant and se_req at t+1.
- Response latency: zero cycles; req_ack and req_nak follow se_ack and se_nak combinationally.
- Back-to-back sessions:
  - The requester drops req at cycle t; IDLE at t+1; the next grant at t+2.
  - A waiting requester therefore sees at most (N-1) sessions plus two cycles of overhead per session.
- Drop with response: req dropping in the same cycle as an ack is legal. The ack is routed and the session ends.
- Reset mid-session: the next cycle has grant=0 and se_req=0. Any pending engine response is discarded.

## Configuration
- SE_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider watchdog clears on session start and on each se_ack or se_nak.
  - It increments in BUSY while no response arrives.
  - When it reaches TIMEOUT, in that cycle: req_nak[g]=1, err_timeout=1, go to FLUSH.
  - FLUSH forces se_req=0, discards engine responses, and holds grant until req[g] drops. Then last_grant is updated and the state returns to IDLE.
- SE_ARB_TIMEOUT_EN undefined:
  - No watchdog and no FLUSH state; BUSY waits indefinitely.
  - err_timeout is tied to 0.

## Test plan
- Reset, then req=4'b0101 -> grant=4'b0001 one cycle later. After requester 0 drops, grant=4'b0100 two cycles later.
- Requester 2 session with source mac 00_11_22_33_44_55:
  - se_ack, then the fields switch to destination mac ff_ff_ff_ff_ff_ff, then se_nak.
  - Required: req_ack=4'b0100, then req_nak=4'b0100, and se_mac carries each value in the cycle it is driven.
- All four requesters request continuously -> grant order 0,1,2,3,0 with exactly one idle cycle of se_req=0 between sessions.
- se_ack with se_result=16'h0008 during requester 1's session -> req_ack=4'b0010 and req_result=16'h0008; no other req_ack bit rises.
- Assert rst while BUSY -> the next cycle has grant=0 and se_req=0. A stray se_ack is not routed.
- With SE_ARB_TIMEOUT_EN and TIMEOUT=16, grant requester 3 with no engine response:
  - 16 cycles later: req_nak=4'b1000, err_timeout pulses, se_req=0.
  - Grant is held until req[3] drops.

Source files
------------

// File: rtl/se_lookup_arbiter.sv
// se_lookup_arbiter: round-robin sharing of one MAC search engine between N frame
// processors, one grant per lookup session. Optional response watchdog: SE_ARB_TIMEOUT_EN.
module se_lookup_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [48*N-1:0] req_mac,
  input  logic [10*N-1:0] req_hash,
  input  logic [N-1:0]    req_source,
  output logic [N-1:0]    req_ack,
  output logic [N-1:0]    req_nak,
  output logic [15:0]     req_result,
  output logic            se_req,
  output logic [47:0]     se_mac,
  output logic [9:0]      se_hash,
  output logic            se_source,
  input  logic            se_ack,
  input  logic            se_nak,
  input  logic [15:0]     se_result,
  output logic [N-1:0]    grant,
  output logic            err_timeout,
  output logic [1:0]      dbg_state
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef SE_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FLUSH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1} state_t;
`endif

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_gidx, r_last, w_sel, w_idx;
  logic          w_found, w_start, w_end, w_req_g, w_timeout, w_active;

  // Round-robin pick: first requesting index strictly after r_last, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(r_last) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_req_g = req[r_gidx];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (!w_req_g) w_state_nxt = S_IDLE;
`ifdef SE_ARB_TIMEOUT_EN
        if (w_timeout) w_state_nxt = S_FLUSH;
`endif
      end
`ifdef SE_ARB_TIMEOUT_EN
      S_FLUSH: if (!w_req_g) w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_start = (r_state == S_IDLE) && w_found;
  assign w_end   = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant <= {{(N-1){1'b0}}, 1'b1} << w_sel;
        r_gidx  <= w_sel;
      end else if (w_end) begin
        r_grant <= '0;
        r_last  <= r_gidx;
      end
    end
  end

`ifdef SE_ARB_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WW-1:0] r_wd;

  // Counts silent BUSY cycles; any engine response restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (w_start || se_ack || se_nak) begin
      r_wd <= '0;
    end else if ((r_state == S_BUSY) && !w_timeout) begin
      r_wd <= r_wd + WW'(1);
    end
  end

  assign w_timeout = (r_state == S_BUSY) && (r_wd == WW'(TIMEOUT));
`else
  // Constant 0 for any legal TIMEOUT; the limit only matters with the watchdog.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // Handshake: the requester holds req (and may update its fields) for the whole
  // session; se_ack/se_nak are single-cycle strobes routed only to the granted port.
  assign w_active = (r_state == S_BUSY) && !w_timeout;

  always_comb begin
    se_req    = 1'b0;
    se_mac    = '0;
    se_hash   = '0;
    se_source = 1'b0;
    req_ack   = '0;
    req_nak   = '0;
    if (w_active) begin
      se_req = w_req_g;
      for (int i = 0; i < N; i++) begin
        if (r_gidx == IW'(i)) begin
          se_mac    = req_mac[48*i +: 48];
          se_hash   = req_hash[10*i +: 10];
          se_source = req_source[i];
        end
      end
      req_ack[r_gidx] = se_ack;
      req_nak[r_gidx] = se_nak;
    end
    if (w_timeout) req_nak[r_gidx] = 1'b1;
  end

  assign req_result  = se_result;
  assign grant       = r_grant;
  assign err_timeout = w_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Bench for se_lookup_arbiter: directed sessions, a routing vector table checked through
// an expected queue, a round-robin order scoreboard and the watchdog (SE_ARB_TIMEOUT_EN).
module tb_se_lookup_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [48*N-1:0] req_mac;
  logic [10*N-1:0] req_hash;
  logic [N-1:0]    req_source;
  logic [N-1:0]    req_ack, req_nak;
  logic [15:0]     req_result;
  logic            se_req;
  logic [47:0]     se_mac;
  logic [9:0]      se_hash;
  logic            se_source;
  logic            se_ack, se_nak;
  logic [15:0]     se_result;
  logic [N-1:0]    grant;
  logic            err_timeout;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [3:0]  grant_q[$];

  typedef struct {
    logic        ack;
    logic        nak;
    logic [15:0] result;
    logic [47:0] mac;
    logic [9:0]  hash;
    logic        src;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_nak;
    logic [15:0] exp_result;
  } vec_t;

  vec_t vecs[5];

  se_lookup_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mac(req_mac), .req_hash(req_hash),
    .req_source(req_source), .req_ack(req_ack), .req_nak(req_nak),
    .req_result(req_result), .se_req(se_req), .se_mac(se_mac), .se_hash(se_hash),
    .se_source(se_source), .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .grant(grant), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req       = '0;
    se_ack    = 1'b0;
    se_nak    = 1'b0;
    se_result = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  initial begin
    logic [3:0]  g_now, prev;
    logic [23:0] e;
    int          sessions, idle_run, hold;
    logic        err_seen;

    req_mac    = {48'hdddd_dddd_0003, 48'hcccc_cccc_0002, 48'hbbbb_bbbb_0001, 48'haaaa_aaaa_0000};
    req_hash   = {10'h303, 10'h202, 10'h101, 10'h0f0};
    req_source = 4'b1010;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 48'h0a0b_0c0d_0e0f, 10'h3ff, 1'b1, 4'b0000, 4'b0000, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 16'h0008, 48'h1111_2222_3333, 10'h001, 1'b0, 4'b0010, 4'b0000, 16'h0008};
    vecs[2] = '{1'b0, 1'b1, 16'hffff, 48'h4444_5555_6666, 10'h155, 1'b1, 4'b0000, 4'b0010, 16'hffff};
    vecs[3] = '{1'b1, 1'b1, 16'ha5a5, 48'h7777_8888_9999, 10'h2aa, 1'b0, 4'b0010, 4'b0010, 16'ha5a5};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 48'h0, 10'h0, 1'b1, 4'b0000, 4'b0000, 16'h0000};
    vecs[4].mac    = {16'($urandom_range(0, 65535)), $urandom};
    vecs[4].hash   = 10'($urandom_range(0, 1023));
    vecs[4].result = 16'($urandom_range(0, 65535));
    vecs[4].exp_result = vecs[4].result;

    // reset state
    do_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_se_req", se_req, 0);
    chk("rst_se_mac", se_mac, 0);
    chk("rst_se_hash", se_hash, 0);
    chk("rst_se_source", se_source, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_req_nak", req_nak, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_state", dbg_state, 0);
    se_ack = 1'b1;
    #1 chk("idle_ack_dropped", req_ack, 0);
    se_ack = 1'b0;

    // grant latency and back-to-back session gap
    req = 4'b0101;
    #1 chk("grant_before_edge", grant, 0);
    tick();
    #1;
    chk("first_grant", grant, 4'b0001);
    chk("first_se_req", se_req, 1);
    chk("first_se_mac", se_mac, 48'haaaa_aaaa_0000);
    chk("first_se_hash", se_hash, 10'h0f0);
    req = 4'b0100;
    req_mac[96 +: 48] = 48'h0011_2233_4455;
    #1;
    chk("drop_cycle_grant", grant, 4'b0001);
    chk("drop_cycle_se_req", se_req, 0);
    tick();
    #1;
    chk("gap_grant", grant, 0);
    chk("gap_se_req", se_req, 0);
    tick();
    #1;
    chk("second_grant", grant, 4'b0100);
    chk("r2_se_mac_src", se_mac, 48'h0011_2233_4455);
    chk("r2_se_source", se_source, 0);

    // requester 2: ack, field switch, nak, then drop together with an ack
    se_ack = 1'b1;
    #1;
    chk("r2_ack", req_ack, 4'b0100);
    chk("r2_ack_nak", req_nak, 0);
    tick();
    se_ack = 1'b0;
    req_mac[96 +: 48] = 48'hffff_ffff_ffff;
    #1;
    chk("r2_se_mac_dst", se_mac, 48'hffff_ffff_ffff);
    chk("r2_ack_clear", req_ack, 0);
    se_nak = 1'b1;
    #1;
    chk("r2_nak", req_nak, 4'b0100);
    chk("r2_nak_ack", req_ack, 0);
    tick();
    se_nak = 1'b0;
    req = 4'b0000;
    se_ack = 1'b1;
    #1 chk("drop_with_ack", req_ack, 4'b0100);
    tick();
    se_ack = 1'b0;
    #1 chk("drop_with_ack_end", grant, 0);

    // round robin with all requesters active; scoreboard of grant order
    do_reset();
    grant_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    prev = '0;
    sessions = 0;
    idle_run = 0;
    hold = 0;
    for (int cyc = 0; cyc < 200 && sessions < 5; cyc++) begin
      tick();
      g_now = grant;
      if (g_now != 0 && prev == 0) begin
        if (grant_q.size() == 0) chk("rr_queue_empty", 1, 0);
        else chk("rr_order", g_now, grant_q.pop_front());
        if (sessions > 0) chk("rr_gap", idle_run, 1);
        sessions++;
        idle_run = 0;
        hold = 0;
      end
      if (g_now != 0) begin
        hold++;
        req = (hold == 3) ? ~g_now : 4'b1111;
      end else begin
        req = 4'b1111;
      end
      #1;
      if (g_now == 0 && se_req == 1'b0) idle_run++;
      prev = g_now;
    end
    chk("rr_sessions", sessions, 5);
    req = '0;
    tick();
    tick();

    // routing vector table during requester 1's session
    do_reset();
    req = 4'b0010;
    tick();
    #1 chk("tbl_grant", grant, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      se_ack = vecs[i].ack;
      se_nak = vecs[i].nak;
      se_result = vecs[i].result;
      req_mac[48 +: 48] = vecs[i].mac;
      req_hash[10 +: 10] = vecs[i].hash;
      req_source[1] = vecs[i].src;
      exp_q.push_back({vecs[i].exp_ack, vecs[i].exp_nak, vecs[i].exp_result});
      #1;
      if (exp_q.size() == 0) begin
        chk("tbl_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tbl_resp", {req_ack, req_nak, req_result}, e);
      end
      chk("tbl_se_mac", se_mac, vecs[i].mac);
      chk("tbl_se_hash", se_hash, vecs[i].hash);
      chk("tbl_se_source", se_source, vecs[i].src);
      chk("tbl_se_req", se_req, 1);
      tick();
    end
    se_ack = 1'b0;
    se_nak = 1'b0;

    // reset while BUSY; a stray ack afterwards must not be routed
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    se_ack = 1'b1;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_se_req", se_req, 0);
    chk("midrst_ack", req_ack, 0);
    chk("midrst_state", dbg_state, 0);
    se_ack = 1'b0;

`ifdef SE_ARB_TIMEOUT_EN
    // watchdog abort after TO silent cycles, grant held in FLUSH
    do_reset();
    req = 4'b1000;
    tick();
    #1 chk("to_grant", grant, 4'b1000);
    for (int k = 1; k <= TO - 1; k++) tick();
    #1;
    chk("to_pre_nak", req_nak, 0);
    chk("to_pre_err", err_timeout, 0);
    chk("to_pre_se_req", se_req, 1);
    tick();
    #1;
    chk("to_nak", req_nak, 4'b1000);
    chk("to_err", err_timeout, 1);
    chk("to_se_req", se_req, 0);
    tick();
    se_ack = 1'b1;
    #1;
    chk("flush_err_pulse", err_timeout, 0);
    chk("flush_grant", grant, 4'b1000);
    chk("flush_se_req", se_req, 0);
    chk("flush_ack_dropped", req_ack, 0);
    chk("flush_state", dbg_state, 2);
    se_ack = 1'b0;
    tick();
    tick();
    tick();
    #1 chk("flush_hold", grant, 4'b1000);
    req = '0;
    tick();
    #1 chk("flush_exit", grant, 0);
`else
    // without the watchdog a silent session simply waits
    do_reset();
    req = 4'b1000;
    tick();
    err_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      #1;
      if (err_timeout !== 1'b0) err_seen = 1'b1;
    end
    chk("nowd_err", err_seen, 0);
    chk("nowd_grant", grant, 4'b1000);
    chk("nowd_se_req", se_req, 1);
    req = '0;
    tick();
    #1 chk("nowd_exit", grant, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
